nfc_rb_monitor: RTL and testbench
=================================

// Module: nfc_rb_monitor
// PURPOSE
//  clk_2x-domain NAND ready/busy monitor; the stage directly upstream of the clk_2x->clk pulse synchronizer.
//  After a command is issued, waits tWB, then watches the synchronized R/B# pin and debounces the busy->ready edge.
//  Emits one single-cycle ready_pulse (or timeout_pulse) per command, spaced so the downstream synchronizer
//  always captures it.
// PARAMETERS
//  TWB_W    8   width of twb_cyc configuration field
//  DEB_LEN  4   consecutive clk_2x cycles rb_s must be high to accept ready (>=1)
//  GAP      4   clk_2x cycles of mandatory quiet after any output pulse (>=4)
//  TO_W     20  width of timeout counter/config (timeout feature only)
// PORTS
//  clk_2x         in   1      fast clock, 2x system clk
//  rst_n          in   1      asynchronous, active-low reset
//  start          in   1      1-cycle pulse: command with busy phase issued
//  twb_cyc        in   TWB_W  tWB wait in clk_2x cycles; sampled at start
//  to_cyc         in   TO_W   busy timeout in clk_2x cycles; sampled at start; 0 = disabled
//  rb_n_pad       in   1      raw R/B# pin, asynchronous (1 = ready)
//  ready_pulse    out  1      1-cycle pulse: device returned ready; feeds pulse_sync.pulse_in
//  timeout_pulse  out  1      1-cycle pulse: busy exceeded to_cyc
//  busy           out  1      high from accepted start until the pulse cycle (inclusive)
//  start_err      out  1      1-cycle pulse: start received while not IDLE
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, all counters 0, sync flops 1 (ready). Reset mid-operation aborts silently; no pulse.
//  rb_n_pad -> 2-flop synchronizer -> rb_s (2-cycle latency).
//  FSM:
//   IDLE: start -> TWB, load cnt=twb_cyc, load to_cnt=to_cyc, busy=1. If twb_cyc==0, go straight to BUSY.
//   TWB:  cnt-- each cycle; at cnt==1 -> BUSY. rb_s ignored (device may not yet drive busy).
//   BUSY: deb counts consecutive rb_s==1 cycles, cleared to 0 on any rb_s==0.
//         deb reaches DEB_LEN -> DONE.
//   DONE: ready_pulse=1 for exactly this cycle; busy=1 this cycle -> GAP state, busy=0.
//   TMO:  timeout_pulse=1 for one cycle -> GAP.
//   GAP:  GAP cycles, no pulses, start here -> start_err, ignored -> IDLE.
//  Latency: rb_n_pad rises (stable) in BUSY -> ready_pulse after 2 + DEB_LEN + 1 clk_2x edges.
//  A device already ready after tWB still needs DEB_LEN high cycles (no shortcut).
//  start while FSM != IDLE: start_err pulse same+1 cycle, state/counters untouched.
//  Simultaneous deb==DEB_LEN and timeout expiry in the same cycle: ready wins; no timeout_pulse.
//  Output pulses never adjacent: minimum spacing between any two output pulses is GAP+2 cycles.
//  Counters saturate/never wrap: twb cnt stops at 1, deb stops at DEB_LEN, to_cnt stops at 0.
// CONFIGURATION
//  NFC_RB_TIMEOUT_EN defined: to_cnt decrements every BUSY cycle when to_cyc!=0; reaching 0 -> TMO.
//  NFC_RB_TIMEOUT_EN undefined: no to_cnt logic, TMO unreachable; timeout_pulse tied 0, to_cyc unused.
//   BUSY waits indefinitely.
// STRUCTURE
//  Shared package nfc_pkg: FSM state encodings (IDLE, TWB, BUSY, DONE, TMO, GAP), default TWB_W/TO_W widths.
//  Sub-module nfc_sync2: generic 2-flop synchronizer with a reset-value parameter, used for rb_n_pad.
//  Remainder (FSM + three counters) stays in this module.
// TESTING
//  1. twb_cyc=5, rb_n_pad low 20 cycles then high -> exactly one ready_pulse 7 cycles (DEB_LEN=4) after rise.
//     busy high throughout.
//  2. rb_n_pad glitch high 3 cycles inside BUSY -> no pulse; deb restarts; pulse only after 4 stable cycles.
//  3. start in TWB, BUSY and GAP -> start_err each time, original command completes with one ready_pulse.
//  4. timeout on: to_cyc=50, rb_n_pad held low -> timeout_pulse at BUSY cycle 50, no ready_pulse.
//     timeout off: no pulse ever.
//  5. rb high on same cycle timeout expires -> ready_pulse only.
//     Back-to-back starts: pulses separated >= GAP+2 and each seen once at pulse_sync.pulse_out (clk domain).
//  6. rst_n asserted in BUSY -> outputs 0 immediately; after release, FSM in IDLE, no spurious pulse.

Source files
------------

// File: rtl/nfc_pkg.sv
// nfc_pkg
//   Shared definitions for the NAND flash controller ready/busy path:
//   default configuration widths and the ready/busy monitor FSM encoding.
//   No ports (package).
package nfc_pkg;

  // Default width of the tWB wait configuration field.
  localparam int TWB_W_DEF = 8;
  // Default width of the busy-timeout counter/configuration.
  localparam int TO_W_DEF  = 20;

  // Ready/busy monitor states.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_TWB  = 3'd1,
    ST_BUSY = 3'd2,
    ST_DONE = 3'd3,
    ST_TMO  = 3'd4,
    ST_GAP  = 3'd5
  } nfc_state_t;

endpackage

// File: rtl/nfc_sync2.sv
// nfc_sync2
//   Generic 2-flop synchronizer for asynchronous level inputs. The reset
//   value is a parameter so the synchronized output starts in the state the
//   consumer treats as benign.
// Ports
//   clk    in   1      destination clock
//   rst_n  in   1      asynchronous, active-low reset
//   d      in   WIDTH  asynchronous input
//   q      out  WIDTH  synchronized output (2-cycle latency)
module nfc_sync2 #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/nfc_rb_monitor.sv
// nfc_rb_monitor
//   clk_2x-domain NAND ready/busy monitor, feeding the clk_2x->clk pulse
//   synchronizer. After a command is issued it waits tWB, then debounces the
//   synchronized R/B# pin and emits exactly one ready_pulse (or, with the
//   timeout feature, timeout_pulse) per command. A mandatory quiet GAP after
//   every output pulse keeps pulses far enough apart for the slow domain.
//
// Handshake: start is a single-cycle strobe with no back-pressure; a start
//   seen outside IDLE is dropped and flagged by start_err one cycle later.
//   ready_pulse / timeout_pulse / start_err are single-cycle strobes with no
//   acknowledge.
//
// Configuration macro: NFC_RB_TIMEOUT_EN
//   defined   -> busy timeout counter active (to_cyc != 0 enables it)
//   undefined -> no timeout logic; timeout_pulse stays 0, to_cyc unused
//
// Ports
//   clk_2x         in   1      fast clock (2x system clk)
//   rst_n          in   1      asynchronous, active-low reset
//   start          in   1      command with busy phase issued (1-cycle)
//   twb_cyc        in   TWB_W  tWB wait in clk_2x cycles, sampled at start
//   to_cyc         in   TO_W   busy timeout in cycles, sampled at start; 0 = off
//   rb_n_pad       in   1      raw asynchronous R/B# pin (1 = ready)
//   ready_pulse    out  1      device returned ready (1-cycle)
//   timeout_pulse  out  1      busy exceeded to_cyc (1-cycle)
//   busy           out  1      accepted start through the pulse cycle
//   start_err      out  1      start received while not IDLE (1-cycle)
module nfc_rb_monitor
  import nfc_pkg::*;
#(
  parameter int TWB_W   = TWB_W_DEF,
  parameter int DEB_LEN = 4,
  parameter int GAP     = 4,
  parameter int TO_W    = TO_W_DEF
) (
  input  logic             clk_2x,
  input  logic             rst_n,
  input  logic             start,
  input  logic [TWB_W-1:0] twb_cyc,
  input  logic [TO_W-1:0]  to_cyc,
  input  logic             rb_n_pad,
  output logic             ready_pulse,
  output logic             timeout_pulse,
  output logic             busy,
  output logic             start_err
);

  localparam int DEB_W = $clog2(DEB_LEN + 1);

  logic             rb_s;
  nfc_sync2 #(.WIDTH(1), .RST_VAL(1'b1)) u_rb_sync (
    .clk   (clk_2x),
    .rst_n (rst_n),
    .d     (rb_n_pad),
    .q     (rb_s)
  );

  nfc_state_t       state;
  // cnt is shared: tWB countdown in TWB, quiet-period countdown in GAP.
  logic [TWB_W-1:0] cnt;
  logic [DEB_W-1:0] deb;
  logic             to_expire;

`ifdef NFC_RB_TIMEOUT_EN
  logic [TO_W-1:0]  to_cnt;

  // Expiry is taken on the BUSY cycle that would bring to_cnt to 0, so a
  // to_cyc of N yields the timeout after exactly N BUSY cycles.
  assign to_expire = (state == ST_BUSY) && (to_cnt == TO_W'(1));

  always_ff @(posedge clk_2x or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (state == ST_IDLE && start) begin
      to_cnt <= to_cyc;
    end else if (state == ST_BUSY && to_cnt != '0) begin
      to_cnt <= to_cnt - 1'b1;
    end
  end
`else
  logic unused_to_cyc;
  assign unused_to_cyc = ^to_cyc;
  assign to_expire     = 1'b0;
`endif

  always_ff @(posedge clk_2x or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      deb           <= '0;
      ready_pulse   <= 1'b0;
      timeout_pulse <= 1'b0;
      busy          <= 1'b0;
      start_err     <= 1'b0;
    end else begin
      start_err     <= start && (state != ST_IDLE);
      ready_pulse   <= 1'b0;
      timeout_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            deb   <= '0;
            cnt   <= twb_cyc;
            state <= (twb_cyc == '0) ? ST_BUSY : ST_TWB;
          end
        end
        ST_TWB: begin
          // rb_s is not trusted yet: the device may not have pulled R/B# low.
          if (cnt <= TWB_W'(1)) state <= ST_BUSY;
          else                  cnt   <= cnt - 1'b1;
        end
        ST_BUSY: begin
          // Ready is tested first so it wins over a same-cycle timeout.
          if (deb == DEB_W'(DEB_LEN)) begin
            state       <= ST_DONE;
            ready_pulse <= 1'b1;
          end else if (to_expire) begin
            state         <= ST_TMO;
            timeout_pulse <= 1'b1;
          end else if (rb_s) begin
            deb <= deb + 1'b1;
          end else begin
            deb <= '0;
          end
        end
        ST_DONE, ST_TMO: begin
          // The pulse is high during this cycle; busy drops with it.
          busy  <= 1'b0;
          cnt   <= TWB_W'(GAP);
          state <= ST_GAP;
        end
        ST_GAP: begin
          if (cnt <= TWB_W'(1)) state <= ST_IDLE;
          else                  cnt   <= cnt - 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nfc_rb_monitor.sv
// tb_nfc_rb_monitor
//   Directed bench for nfc_rb_monitor. Latencies are counted in clk_2x edges
//   from the negedge where the stimulus is applied to the negedge where the
//   pulse is seen. Each command pushes its expected pulse kind into exp_q;
//   every pulse the DUT emits is popped and compared.
module tb_nfc_rb_monitor;

  localparam int TWB_W   = 8;
  localparam int TO_W    = 20;
  localparam int DEB_LEN = 4;
  localparam int GAP     = 4;

  localparam logic [1:0] K_READY = 2'b01;
  localparam logic [1:0] K_TMO   = 2'b10;

  // ---------------- clock / reset ----------------
  logic clk_2x = 1'b0;
  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  always #5  clk_2x = ~clk_2x;
  always #10 clk    = ~clk;

  logic             start    = 1'b0;
  logic [TWB_W-1:0] twb_cyc  = '0;
  logic [TO_W-1:0]  to_cyc   = '0;
  logic             rb_n_pad = 1'b1;
  logic             ready_pulse, timeout_pulse, busy, start_err;

  nfc_rb_monitor #(
    .TWB_W   (TWB_W),
    .DEB_LEN (DEB_LEN),
    .GAP     (GAP),
    .TO_W    (TO_W)
  ) dut (
    .clk_2x        (clk_2x),
    .rst_n         (rst_n),
    .start         (start),
    .twb_cyc       (twb_cyc),
    .to_cyc        (to_cyc),
    .rb_n_pad      (rb_n_pad),
    .ready_pulse   (ready_pulse),
    .timeout_pulse (timeout_pulse),
    .busy          (busy),
    .start_err     (start_err)
  );

  // ---------------- scoreboard ----------------
  int         n_cmp     = 0;
  int         n_bad     = 0;
  int         n_ready   = 0;
  int         exp_ready = 0;
  int         n_sync    = 0;
  logic [1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk_2x) begin
    if (rst_n && (ready_pulse || timeout_pulse)) begin
      if (ready_pulse) n_ready++;
      if (exp_q.size() == 0)
        check_eq("unexpected_pulse", {30'd0, timeout_pulse, ready_pulse}, 32'd0);
      else
        check_eq("pulse_kind", {30'd0, timeout_pulse, ready_pulse},
                 {30'd0, exp_q.pop_front()});
    end
  end

  // Toggle-style clk_2x -> clk pulse synchronizer standing in for pulse_sync.
  logic tgl = 1'b0, s1 = 1'b0, s2 = 1'b0, s3 = 1'b0;
  always @(posedge clk_2x) if (ready_pulse) tgl <= ~tgl;
  always @(posedge clk) begin
    s1 <= tgl;
    s2 <= s1;
    s3 <= s2;
    if (s2 ^ s3) n_sync <= n_sync + 1;
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input int twb, input int to, input logic [1:0] kind);
    twb_cyc = TWB_W'(twb);
    to_cyc  = TO_W'(to);
    start   = 1'b1;
    exp_q.push_back(kind);
    if (kind == K_READY) exp_ready++;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_2x);
  endtask

  // Counts edges until a pulse is seen; edges = 0 if the bound expires.
  task automatic wait_pulse(input int max_edges, input bit hold_start,
                            output int edges, output int busy_low);
    edges    = 0;
    busy_low = 0;
    while (edges < max_edges) begin
      @(posedge clk_2x);
      edges++;
      @(negedge clk_2x);
      if (!hold_start) start = 1'b0;
      if (ready_pulse || timeout_pulse) return;
      if (!busy) busy_low++;
    end
    edges = 0;
  endtask

  task automatic spurious_start(input string tag);
    twb_cyc = TWB_W'(0);
    start   = 1'b1;
    @(negedge clk_2x);
    start = 1'b0;
    check_eq(tag, start_err, 1);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int e, bl;

    rb_n_pad = 1'b1;
    idle(3);
    check_eq("rst_ready",   ready_pulse,   0);
    check_eq("rst_timeout", timeout_pulse, 0);
    check_eq("rst_busy",    busy,          0);
    check_eq("rst_err",     start_err,     0);

    // Sync flops come out of reset at 1: device already ready, twb=0.
    rst_n = 1'b1;
    issue(0, 0, K_READY);
    wait_pulse(40, 0, e, bl);
    check_eq("t0_latency_twb0", e, 6);
    idle(8);

    // Test 1: twb=5, pad low 20 cycles then high.
    rb_n_pad = 1'b0;
    issue(5, 0, K_READY);
    @(negedge clk_2x);
    start = 1'b0;
    check_eq("t1_busy_start", busy, 1);
    check_eq("t1_no_err",     start_err, 0);
    idle(19);
    rb_n_pad = 1'b1;
    wait_pulse(40, 0, e, bl);
    check_eq("t1_latency",       e,    7);
    check_eq("t1_busy_gaps",     bl,   0);
    check_eq("t1_busy_at_pulse", busy, 1);
    @(negedge clk_2x);
    check_eq("t1_busy_after",  busy,        0);
    check_eq("t1_single_cyc",  ready_pulse, 0);
    idle(8);

    // twb=1: one TWB cycle, device ready -> one cycle more than twb=0.
    issue(1, 0, K_READY);
    wait_pulse(40, 0, e, bl);
    check_eq("twb1_latency", e, 7);
    idle(8);

    // Test 2: 3-cycle glitch high inside BUSY must not complete.
    rb_n_pad = 1'b0;
    issue(2, 0, K_READY);
    @(negedge clk_2x);
    start = 1'b0;
    idle(8);
    rb_n_pad = 1'b1;
    idle(3);
    rb_n_pad = 1'b0;
    idle(10);
    check_eq("t2_busy_after_glitch", busy, 1);
    rb_n_pad = 1'b1;
    wait_pulse(40, 0, e, bl);
    check_eq("t2_latency", e, 7);
    idle(8);

    // Test 3: start in TWB, BUSY and GAP.
    rb_n_pad = 1'b0;
    issue(10, 0, K_READY);
    @(negedge clk_2x);
    start = 1'b0;
    idle(2);
    twb_cyc = TWB_W'(200);
    start   = 1'b1;
    @(negedge clk_2x);
    start = 1'b0;
    check_eq("t3_err_twb", start_err, 1);
    @(negedge clk_2x);
    check_eq("t3_err_one_cycle", start_err, 0);
    idle(12);
    spurious_start("t3_err_busy");
    rb_n_pad = 1'b1;
    wait_pulse(40, 0, e, bl);
    check_eq("t3_latency", e, 7);
    @(negedge clk_2x);
    spurious_start("t3_err_gap");
    idle(10);
    check_eq("t3_gap_start_ignored", busy, 0);

    // Test 4: timeout with pad held low.
    rb_n_pad = 1'b0;
`ifdef NFC_RB_TIMEOUT_EN
    issue(0, 50, K_TMO);
    wait_pulse(80, 0, e, bl);
    check_eq("t4_tmo_latency", e, 51);
    check_eq("t4_tmo_pulse",   timeout_pulse, 1);
    check_eq("t4_no_ready",    ready_pulse,   0);
    @(negedge clk_2x);
    check_eq("t4_busy_after",  busy, 0);
    idle(8);
`else
    issue(0, 50, K_READY);
    @(negedge clk_2x);
    start = 1'b0;
    idle(120);
    check_eq("t4_still_busy", busy, 1);
    rb_n_pad = 1'b1;
    wait_pulse(40, 0, e, bl);
    check_eq("t4_late_ready_latency", e, 7);
    idle(8);
`endif

    // Test 5: ready reached on the cycle the timeout would expire.
    rb_n_pad = 1'b1;
    idle(4);
    issue(0, 5, K_READY);
    wait_pulse(40, 0, e, bl);
    check_eq("t5_ready_wins", e, 6);
    idle(8);
`ifdef NFC_RB_TIMEOUT_EN
    issue(0, 4, K_TMO);
    wait_pulse(40, 0, e, bl);
    check_eq("t5_tmo_first", e, 5);
`else
    issue(0, 4, K_READY);
    wait_pulse(40, 0, e, bl);
    check_eq("t5_no_tmo", e, 6);
`endif
    idle(8);

    // Back-to-back: start held high, device always ready.
    twb_cyc = TWB_W'(0);
    to_cyc  = TO_W'(0);
    for (int i = 0; i < 4; i++) begin
      issue(0, 0, K_READY);
      wait_pulse(40, 1, e, bl);
      if (i == 0) check_eq("b2b_first", e, 6);
      else begin
        check_eq("b2b_spacing", e, 11);
        check_eq("b2b_min_gap", (e >= GAP + 2), 1);
      end
    end
    start = 1'b0;
    idle(10);

    // Test 6: reset while BUSY.
    rb_n_pad = 1'b0;
    twb_cyc  = TWB_W'(0);
    start    = 1'b1;
    @(negedge clk_2x);
    start = 1'b0;
    idle(4);
    check_eq("t6_busy_before_rst", busy, 1);
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_busy",  busy,          0);
    check_eq("t6_rst_ready", ready_pulse,   0);
    check_eq("t6_rst_tmo",   timeout_pulse, 0);
    @(negedge clk_2x);
    rst_n = 1'b1;
    idle(5);
    rb_n_pad = 1'b1;
    idle(15);
    check_eq("t6_idle_after_rst", busy, 0);
    issue(0, 0, K_READY);
    wait_pulse(40, 0, e, bl);
    check_eq("t6_new_cmd_latency", e, 6);
    idle(20);

    check_eq("sync_pulse_count", n_sync,        n_ready);
    check_eq("ready_count",      n_ready,       exp_ready);
    check_eq("exp_q_empty",      exp_q.size(),  0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
